// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-entry skid/holding register so that
// consecutive words stream out with no gap cycles.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1,
    parameter bit IDLE_LEVEL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]       state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] word, word_nx;
    logic [WIDTH-1:0] hold, hold_nx;
    logic             hold_full, hold_full_nx;
    logic             accept;
    logic             last;
    logic             next_bit;

    assign data_ready = !hold_full && !reset;
    assign accept     = data_valid && data_ready;
    assign last       = (cnt == LAST);
    assign busy       = (state == S_SHIFT) || hold_full;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        word_nx      = word;
        hold_nx      = hold;
        hold_full_nx = hold_full;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    word_nx  = data_in;
                    cnt_nx   = '0;
                    state_nx = S_SHIFT;
                end
            end
            default: begin
                if (!last) begin
                    cnt_nx = cnt + 1'b1;
                    if (accept) begin
                        hold_nx      = data_in;
                        hold_full_nx = 1'b1;
                    end
                end else if (hold_full) begin
                    // Held word takes priority; ready was low so nothing new arrives.
                    word_nx      = hold;
                    hold_full_nx = 1'b0;
                    cnt_nx       = '0;
                end else if (accept) begin
                    word_nx = data_in;
                    cnt_nx  = '0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
        endcase
    end

    // Output bit is picked from the next word/count so seq_out is a flop with latency 1.
    assign next_bit = MSB_FIRST ? word_nx[LAST - cnt_nx] : word_nx[cnt_nx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            word      <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            seq_out   <= IDLE_LEVEL;
            seq_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            word      <= word_nx;
            hold      <= hold_nx;
            hold_full <= hold_full_nx;
            seq_out   <= (state_nx == S_SHIFT) ? next_bit : IDLE_LEVEL;
            seq_valid <= (state_nx == S_SHIFT);
            word_done <= (state_nx == S_SHIFT) && (cnt_nx == LAST);
        end
    end

endmodule
